// File: rtl/at_seq_pkg.sv
// Shared types and character constants for the AT command sequencer.
package at_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StSend,
    StWaitResp,
    StDone,
    StFail
  } seq_state_e;

  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_NUL = 8'h00;
  localparam logic [7:0] CHR_O   = 8'h4F;
  localparam logic [7:0] CHR_K   = 8'h4B;
  localparam logic [7:0] CHR_R   = 8'h52;

endpackage

// File: rtl/resp_matcher.sv
// Four-byte response window; pulses ok/err on the byte that completes "OK\r\n" or "OR\r\n".
module resp_matcher
  import at_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       ok_o,
  output logic       err_o
);

  localparam logic [31:0] PatOk  = {CHR_O, CHR_K, CHR_CR, CHR_LF};
  localparam logic [31:0] PatErr = {CHR_O, CHR_R, CHR_CR, CHR_LF};

  logic [31:0] shift_q, shift_d;

  always_comb begin
    shift_d = {shift_q[23:0], rx_data_i};
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      shift_q <= '0;
    end else if (rx_valid_i) begin
      shift_q <= shift_d;
    end
  end

  // Decode on the incoming byte so the match is seen in the cycle it arrives.
  always_comb begin
    ok_o  = rx_valid_i && !clr_i && (shift_d == PatOk);
    err_o = rx_valid_i && !clr_i && (shift_d == PatErr);
  end

endmodule

// File: rtl/at_cmd_seq.sv
// Replays LF-terminated AT commands from a ROM to a UART and waits for OK/ERROR per command.
module at_cmd_seq
  import at_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RetryMax    = RW'(MAX_RETRY);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH-1:0] cmd_base_q, cmd_base_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [TW-1:0]         tout_q, tout_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  match_clr;
  logic                  resp_ok, resp_err;
  logic                  timed_out;

  resp_matcher u_resp_matcher (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (match_clr),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid && (state_q == StWaitResp)),
    .ok_o       (resp_ok),
    .err_o      (resp_err)
  );

  assign timed_out = (tout_q == TimeoutLast);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    cmd_base_d = cmd_base_q;
    retry_d    = retry_q;
    tout_d     = tout_q;
    tx_data_d  = tx_data_q;
    match_clr  = 1'b0;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          state_d    = StFetch;
          rom_addr_d = '0;
          cmd_base_d = '0;
          retry_d    = '0;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        tx_data_d = rom_data;
        if ((rom_data == CHR_NUL) && (rom_addr_q == cmd_base_q)) begin
          state_d = StDone;
        end else begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (tx_ready) begin
          rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
          if (tx_data_q == CHR_LF) begin
            state_d   = StWaitResp;
            tout_d    = '0;
            match_clr = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StWaitResp: begin
        // A match wins over a timeout landing in the same cycle.
        if (resp_ok) begin
          cmd_base_d = rom_addr_q;
          retry_d    = '0;
          state_d    = StFetch;
        end else if (resp_err || timed_out) begin
          if (retry_q < RetryMax) begin
            retry_d    = retry_q + RW'(1);
            rom_addr_d = cmd_base_q;
            state_d    = StFetch;
          end else begin
            state_d = StFail;
          end
        end else if (!timed_out) begin
          tout_d = tout_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      cmd_base_q <= '0;
      retry_q    <= '0;
      tout_q     <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      cmd_base_q <= cmd_base_d;
      retry_q    <= retry_d;
      tout_q     <= tout_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    rom_addr = rom_addr_q;
    tx_data  = tx_data_q;
    tx_valid = (state_q == StSend);
    rx_ready = 1'b1;
    done     = (state_q == StDone);
    error    = (state_q == StFail);
    busy     = !((state_q == StIdle) || (state_q == StDone) || (state_q == StFail));
  end

endmodule

// File: doc/at_cmd_seq.md
AT_CMD_SEQ -- requirements
Module: at_cmd_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, command-ROM address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 100_000_000, response wait limit in clk cycles (1 s at 100 MHz).
REQ-003 Parameter MAX_RETRY, default 3, number of re-sends of one command after its first failure.
REQ-004 Ports; one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins the script at address 0.
- rom_addr  out  ADDR_WIDTH  command-ROM address.
- rom_data  in  8  ROM byte; valid one cycle after rom_addr.
- tx_data  out  8  byte to the PMOD UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte.
- rx_data  in  8  byte from the PMOD UART receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  sequencer accepts the rx byte.
- busy  out  1  script in progress.
- done  out  1  script completed; held until the next start.
- error  out  1  script aborted; held until the next start.

Function
REQ-005 The ROM script shall be a sequence of commands, each ending in LF (0x0A) inclusive; a NUL (0x00) byte in command-start position shall end the script.
REQ-006 The states shall be IDLE, FETCH, LOAD, SEND, WAIT_RESP, DONE and FAIL.
REQ-007 IDLE/DONE/FAIL shall move to FETCH on start=1, clear done/error, set busy, and load rom_addr=0 and cmd_base=0.
REQ-008 FETCH shall last exactly one cycle (ROM latency); LOAD shall register rom_data.
REQ-009 In LOAD, a NUL at rom_addr==cmd_base shall go to DONE; any other byte shall go to SEND.
REQ-010 In SEND, tx_valid shall be 1 with tx_data stable until the tx_ready&tx_valid cycle.
- Accepted non-LF byte: rom_addr+1, go to FETCH.
- Accepted LF: rom_addr+1, clear the timeout counter, go to WAIT_RESP.
REQ-011 rx_ready shall be 1 in every state; rx bytes received outside WAIT_RESP shall be discarded and shall not affect matching.
REQ-012 In WAIT_RESP, a 4-byte shift register of accepted rx bytes shall detect "OK\r\n" (success) and "OR\r\n", the tail of ERROR (failure); it shall be cleared on WAIT_RESP entry.
REQ-013 Success shall set cmd_base=rom_addr, clear the retry count, and go to FETCH.
REQ-014 Failure, or the timeout counter reaching TIMEOUT_CYCLES-1, shall, if retry_cnt<MAX_RETRY, increment retry_cnt, set rom_addr=cmd_base, and go to FETCH; otherwise it shall go to FAIL.
REQ-015 Match and timeout in the same cycle shall resolve to the match.
REQ-016 rom_addr shall wrap modulo 2^ADDR_WIDTH; a script without NUL shall continue from address 0.
REQ-017 DONE shall drive done=1, busy=0; FAIL shall drive error=1, busy=0; start outside IDLE/DONE/FAIL shall be ignored.
REQ-018 The timeout counter shall be $clog2(TIMEOUT_CYCLES) bits, saturating, and counting only in WAIT_RESP.

Reset
REQ-019 While rst=1 at a clk edge: state=IDLE, rom_addr=0, cmd_base=0, retry_cnt=0, tx_valid=0, tx_data=0, busy=0, done=0, error=0, match register cleared, timeout counter=0; rx_ready=1.
REQ-020 rst mid-transfer shall drop tx_valid on the following cycle, and no further byte shall be sent until the next start.

Structure
REQ-021 Package at_seq_pkg shall hold the state enum and the constants CHR_CR=0x0D, CHR_LF=0x0A, CHR_NUL=0x00, CHR_O=0x4F, CHR_K=0x4B, CHR_R=0x52.
REQ-022 The response detector shall be the sub-module resp_matcher (rx byte/strobe and clear in; ok and err pulses out).

Verification
REQ-023 ROM "AT\r\n",NUL; start; reply "\r\nOK\r\n" -> tx bytes 0x41,0x54,0x0D,0x0A, then done=1 and busy=0.
REQ-024 Two commands "AT\r\n","AT+CWMODE=1\r\n",NUL, both answered OK -> 17 bytes sent in order, then done=1.
REQ-025 TIMEOUT_CYCLES=1000, no reply -> "AT\r\n" sent 4 times (1+MAX_RETRY), at least 1000 cycles apart, then error=1.
REQ-026 Reply "ERROR\r\n" once, then "OK\r\n" -> the command is re-sent once from cmd_base, then done=1 and error=0.
REQ-027 tx_ready held low for 20 cycles mid-byte -> tx_valid and tx_data stay stable and no byte is lost.
REQ-028 rst asserted during SEND of the 2nd byte -> tx_valid=0 on the next cycle, all outputs at reset values, and a new start resends from address 0.
